// File: rtl/mdr_mem_port.sv
//------------------------------------------------------------------------------
// mdr_mem_port
//   Memory Data Register with a memory handshake port. The MDR can be loaded
//   directly from the internal bus in one cycle, or filled or stored through a
//   request/acknowledge memory transaction run by a small FSM
//   (IDLE -> RD/WR -> DONE -> IDLE). The control unit issues a command while
//   the port is idle and then waits for the one-cycle done pulse.
//
//   Build option:
//     MDR_TIMEOUT_EN  when defined, a pending RD/WR is abandoned after TIMEOUT
//                     cycles without mem_ack. The port then finishes through
//                     DONE and raises the sticky err flag. When undefined,
//                     RD/WR wait for mem_ack indefinitely and err is tied to 0.
//
// Parameters
//   DATA_W   width of MDR, bus and memory data
//   ADDR_W   width of memory address
//   TIMEOUT  wait limit in cycles for mem_ack (timeout build only), >= 1
//
// Ports
//   clk        clock, all state changes on the rising edge
//   clear      synchronous active-high reset
//   MDRin      load command; with Read=0 loads busMuxOut, with Read=1 reads memory
//   Read       source select for MDRin
//   Write      memory write command (stores MDR); MDRin has priority
//   addr       transaction address, captured when a RD/WR command is accepted
//   busMuxOut  internal bus data
//   mem_rdata  memory read data, valid together with mem_ack
//   mem_ack    memory completion
//   mem_req    memory request, high for the whole RD/WR state
//   mem_we     1 = write transaction, 0 = read
//   mem_addr   captured transaction address
//   mem_wdata  write data (always the MDR contents)
//   mdr_out    MDR contents, drives the internal bus
//   busy       high in RD, WR and DONE
//   done       one-cycle pulse when a memory transaction finishes
//   err        timeout flag, sticky until the next accepted RD/WR command
//------------------------------------------------------------------------------
module mdr_mem_port #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 9,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              MDRin,
   input  logic              Read,
   input  logic              Write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] busMuxOut,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mdr_out,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   r_mdr;
   logic [ADDR_W-1:0]   r_addr;

   logic                w_mem_busy;   // in RD or WR
   logic                w_load_bus;   // single-cycle MDR load from the bus
   logic                w_accept;     // RD/WR command accepted this edge
   logic                w_load_rd;    // read data returned this edge
   logic                w_expired;    // wait limit reached this cycle

   if (TIMEOUT < 1) begin : g_timeout_check
      $error("mdr_mem_port: TIMEOUT must be >= 1");
   end

   assign w_mem_busy = (r_state == S_RD) || (r_state == S_WR);

   //---------------------------------------------------------------------------
   // Optional wait-limit counter
   //---------------------------------------------------------------------------
`ifdef MDR_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
   logic             w_timeout;

   assign w_expired = (r_cnt == CNT_W'(TIMEOUT));
   // Ack at the limit edge wins: only an unanswered limit counts as a timeout.
   assign w_timeout = w_mem_busy && !mem_ack && w_expired;

   always_ff @(posedge clk) begin
      if (clear) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cnt <= '0;
            r_err <= 1'b0;
         end else if (w_mem_busy && !w_expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_timeout) begin
            r_err <= 1'b1;
         end
      end
   end

   assign err = r_err;
`else
   assign w_expired = 1'b0;
   assign err       = 1'b0;
`endif

   //---------------------------------------------------------------------------
   // State and data registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the values from before the edge, independent of statement order.
      if (clear) begin
         // NOTE: the data registers are reset as well, because an aborted
         // transaction must leave a zeroed MDR and address behind.
         r_state <= S_IDLE;
         r_mdr   <= '0;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load_bus) begin
            r_mdr <= busMuxOut;
         end else if (w_load_rd) begin
            r_mdr <= mem_rdata;
         end
         if (w_accept) begin
            r_addr <= addr;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Next-state decode
   //---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      w_state_nxt = r_state;
      w_load_bus  = 1'b0;
      w_accept    = 1'b0;
      w_load_rd   = 1'b0;

      case (r_state)
         S_IDLE: begin
            // MDRin outranks Write; a bus load completes without a done pulse.
            if (MDRin) begin
               if (Read) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_RD;
               end else begin
                  w_load_bus  = 1'b1;
               end
            end else if (Write) begin
               w_accept    = 1'b1;
               w_state_nxt = S_WR;
            end
         end
         S_RD: begin
            if (mem_ack) begin
               w_load_rd   = 1'b1;
               w_state_nxt = S_DONE;
            end else if (w_expired) begin
               w_state_nxt = S_DONE;
            end
         end
         S_WR: begin
            if (mem_ack || w_expired) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Outputs, decoded from registered state only
   //---------------------------------------------------------------------------
   assign mem_req   = w_mem_busy;
   assign mem_we    = (r_state == S_WR);
   assign mem_addr  = r_addr;
   assign mem_wdata = r_mdr;
   assign mdr_out   = r_mdr;
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_mdr_mem_port.sv
//------------------------------------------------------------------------------
// tb_mdr_mem_port
//   Self-checking bench for mdr_mem_port. A transaction-level reference model
//   tracks every cycle. Directed vectors from a table, hand-written multi-cycle
//   sequences (delayed ack, clear mid-read, wait limit), and a randomized run
//   are all compared against it.
//------------------------------------------------------------------------------
module tb_mdr_mem_port;

   localparam int DW  = 32;
   localparam int AW  = 9;
   localparam int TMO = 4;
`ifdef MDR_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          clear, mdrin, rd, wr, ack;
   logic [AW-1:0] addr;
   logic [DW-1:0] bus, rdata;
   logic          mem_req, mem_we, busy, done, err;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mdr_out;

   always #5 clk = ~clk;

   mdr_mem_port #(
      .DATA_W  (DW),
      .ADDR_W  (AW),
      .TIMEOUT (TMO)
   ) u_dut (
      .clk       (clk),
      .clear     (clear),
      .MDRin     (mdrin),
      .Read      (rd),
      .Write     (wr),
      .addr      (addr),
      .busMuxOut (bus),
      .mem_rdata (rdata),
      .mem_ack   (ack),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mdr_out   (mdr_out),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   //---------------------------------------------------------------------------
   // Reference model: one outstanding transaction, described by flags.
   //---------------------------------------------------------------------------
   bit            m_txn  = 1'b0;   // memory transaction outstanding
   bit            m_wr   = 1'b0;   // outstanding transaction is a write
   bit            m_done = 1'b0;   // completion being reported this cycle
   bit            m_err  = 1'b0;
   int            m_wait = 0;      // edges seen without ack
   logic [DW-1:0] m_mdr  = '0;
   logic [AW-1:0] m_addr = '0;

   task automatic model_step();
      if (clear) begin
         m_txn = 1'b0; m_wr = 1'b0; m_done = 1'b0; m_err = 1'b0;
         m_wait = 0; m_mdr = '0; m_addr = '0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_txn) begin
         if (ack) begin
            if (!m_wr) m_mdr = rdata;
            m_txn  = 1'b0;
            m_done = 1'b1;
         end else if (TMO_EN && m_wait == TMO) begin
            m_txn  = 1'b0;
            m_done = 1'b1;
            m_err  = 1'b1;
         end else begin
            m_wait++;
         end
      end else if (mdrin && !rd) begin
         m_mdr = bus;
      end else if (mdrin || wr) begin
         m_txn  = 1'b1;
         m_wr   = !mdrin;
         m_wait = 0;
         m_err  = 1'b0;
         m_addr = addr;
      end
   endtask

   task automatic model_check(input string tag);
      check({tag, " mem_req"},   DW'(mem_req),   DW'(m_txn));
      check({tag, " mem_we"},    DW'(mem_we),    DW'(m_txn && m_wr));
      check({tag, " mem_addr"},  DW'(mem_addr),  DW'(m_addr));
      check({tag, " mem_wdata"}, mem_wdata,      m_mdr);
      check({tag, " mdr_out"},   mdr_out,        m_mdr);
      check({tag, " busy"},      DW'(busy),      DW'(m_txn || m_done));
      check({tag, " done"},      DW'(done),      DW'(m_done));
      check({tag, " err"},       DW'(err),       DW'(m_err));
   endtask

   // One clock: inputs already applied, model follows the edge, outputs
   // compared 1 ns later.
   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      #1;
      model_check(tag);
   endtask

   task automatic idle_inputs();
      clear = 1'b0; mdrin = 1'b0; rd = 1'b0; wr = 1'b0; ack = 1'b0;
   endtask

   //---------------------------------------------------------------------------
   // Directed vector table
   //---------------------------------------------------------------------------
   typedef struct {
      logic          clr, mi, rdd, wrr, ak;
      logic [AW-1:0] a;
      logic [DW-1:0] b, rdat;
      logic [DW-1:0] e_mdr;
      logic          e_req, e_we;
      logic [AW-1:0] e_addr;
      logic          e_busy, e_done;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int req_cycles;

      idle_inputs();
      addr = '0; bus = '0; rdata = '0;

      //         clr   MDRin Read  Write ack   addr     bus           rdata         exp mdr       req   we    exp addr busy  done
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 32'h00000001, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 9'h012, 32'h00000000, 32'h00000010, 32'h00000001, 1'b1, 1'b0, 9'h012, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 32'h00000000, 32'h00000010, 32'h00000010, 1'b0, 1'b0, 9'h012, 1'b1, 1'b1};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h000, 32'h00000000, 32'h00000010, 32'h00000010, 1'b0, 1'b0, 9'h012, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h0FF, 32'hAAAA5555, 32'h00000000, 32'hAAAA5555, 1'b0, 1'b0, 9'h012, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h033, 32'h00000000, 32'h00000000, 32'hAAAA5555, 1'b1, 1'b0, 9'h033, 1'b1, 1'b0};
      tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h1FF, 32'h11111111, 32'h00000000, 32'hAAAA5555, 1'b1, 1'b0, 9'h033, 1'b1, 1'b0};
      tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 9'h000, 32'h22222222, 32'h5A5A0000, 32'h5A5A0000, 1'b0, 1'b0, 9'h033, 1'b1, 1'b1};
      tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'h044, 32'h00000000, 32'h00000000, 32'h5A5A0000, 1'b0, 1'b0, 9'h033, 1'b0, 1'b0};

      #2;
      for (int i = 0; i < 10; i++) begin
         clear = tbl[i].clr; mdrin = tbl[i].mi; rd = tbl[i].rdd; wr = tbl[i].wrr;
         ack = tbl[i].ak; addr = tbl[i].a; bus = tbl[i].b; rdata = tbl[i].rdat;
         tick($sformatf("vec%0d model", i));
         check($sformatf("vec%0d mdr_out", i),  mdr_out,        tbl[i].e_mdr);
         check($sformatf("vec%0d mem_req", i),  DW'(mem_req),   DW'(tbl[i].e_req));
         check($sformatf("vec%0d mem_we", i),   DW'(mem_we),    DW'(tbl[i].e_we));
         check($sformatf("vec%0d mem_addr", i), DW'(mem_addr),  DW'(tbl[i].e_addr));
         check($sformatf("vec%0d busy", i),     DW'(busy),      DW'(tbl[i].e_busy));
         check($sformatf("vec%0d done", i),     DW'(done),      DW'(tbl[i].e_done));
      end

      // Write with ack delayed three cycles: request held four cycles.
      idle_inputs(); mdrin = 1'b1; bus = 32'hCAFE0001;
      tick("wr load");
      idle_inputs(); wr = 1'b1; addr = 9'h0A0;
      tick("wr cmd");
      idle_inputs();
      req_cycles = 0;
      for (int k = 0; k < 4; k++) begin
         if (mem_req && mem_we && mem_wdata == 32'hCAFE0001) req_cycles++;
         ack = (k == 3);
         tick("wr wait");
      end
      check("wr request cycles", DW'(req_cycles), 32'd4);
      check("wr done", DW'(done), 32'd1);
      check("wr mdr kept", mdr_out, 32'hCAFE0001);
      idle_inputs();
      tick("wr idle");
      check("wr done one cycle", DW'(done), 32'd0);

      // clear while a read awaits ack; a late ack is then ignored.
      idle_inputs(); mdrin = 1'b1; rd = 1'b1; addr = 9'h155;
      tick("abort cmd");
      idle_inputs();
      tick("abort wait1");
      tick("abort wait2");
      clear = 1'b1;
      tick("abort clear");
      check("abort mem_req", DW'(mem_req), 32'd0);
      check("abort busy", DW'(busy), 32'd0);
      check("abort mdr zero", mdr_out, 32'h0);
      idle_inputs(); ack = 1'b1; rdata = 32'hDEADBEEF;
      tick("late ack1");
      tick("late ack2");
      check("late ack mdr", mdr_out, 32'h0);
      check("late ack busy", DW'(busy), 32'd0);
      idle_inputs();

`ifdef MDR_TIMEOUT_EN
      // Read without ack runs into the limit.
      mdrin = 1'b1; bus = 32'h12345678;
      tick("tmo load");
      idle_inputs(); mdrin = 1'b1; rd = 1'b1; addr = 9'h077;
      tick("tmo cmd");
      idle_inputs();
      req_cycles = 0;
      for (int k = 0; k < TMO + 1; k++) begin
         if (mem_req) req_cycles++;
         tick("tmo wait");
      end
      check("tmo request cycles", DW'(req_cycles), DW'(TMO + 1));
      check("tmo done", DW'(done), 32'd1);
      check("tmo err", DW'(err), 32'd1);
      check("tmo mdr kept", mdr_out, 32'h12345678);
      tick("tmo idle");
      check("tmo err sticky", DW'(err), 32'd1);
      mdrin = 1'b1; rd = 1'b1; addr = 9'h078; ack = 1'b1; rdata = 32'h0BADF00D;
      tick("tmo next cmd");
      check("tmo err cleared", DW'(err), 32'd0);
      idle_inputs(); ack = 1'b1;
      tick("tmo next ack");
      idle_inputs();
      tick("tmo next idle");

      // Ack arriving exactly at the limit edge completes normally.
      mdrin = 1'b1; rd = 1'b1; addr = 9'h079;
      tick("lim cmd");
      idle_inputs();
      for (int k = 0; k < TMO + 1; k++) begin
         ack = (k == TMO); rdata = 32'hA5A5A5A5;
         tick("lim wait");
      end
      check("lim done", DW'(done), 32'd1);
      check("lim err", DW'(err), 32'd0);
      check("lim data", mdr_out, 32'hA5A5A5A5);
      idle_inputs();
      tick("lim idle");
`else
      // Without the wait limit a read holds its request until ack.
      mdrin = 1'b1; rd = 1'b1; addr = 9'h077;
      tick("hold cmd");
      idle_inputs();
      for (int k = 0; k < 20; k++) tick("hold wait");
      check("hold mem_req", DW'(mem_req), 32'd1);
      check("hold err", DW'(err), 32'd0);
      ack = 1'b1; rdata = 32'h600DCAFE;
      tick("hold ack");
      check("hold done", DW'(done), 32'd1);
      check("hold data", mdr_out, 32'h600DCAFE);
      idle_inputs();
      tick("hold idle");
`endif

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         clear = ($urandom_range(0, 49) == 0);
         mdrin = ($urandom_range(0, 2) == 0);
         rd    = $urandom_range(0, 1) == 1;
         wr    = ($urandom_range(0, 2) == 0);
         ack   = ($urandom_range(0, 4) < 2);
         addr  = AW'($urandom);
         bus   = $urandom;
         rdata = $urandom;
         tick("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
